// File: rtl/dsp_macro_pkg.sv
// rtl/dsp_macro_pkg.sv - shared constants and width helpers for the dsp_macro datapath
//
// Purpose: operation select codes, SEL bit positions and width helpers used by
//          dsp_macro, dsp_preadd_mult and the bench.
// Ports:   none (package).

package dsp_macro_pkg;

  // Operation codes carried on SEL
  localparam logic [1:0] OP_AB    = 2'b00;  // A*B + CARRYIN
  localparam logic [1:0] OP_AB_C  = 2'b01;  // A*B + C + CARRYIN
  localparam logic [1:0] OP_ADB   = 2'b10;  // (A+D)*B + CARRYIN
  localparam logic [1:0] OP_ADB_C = 2'b11;  // (A+D)*B + C + CARRYIN

  // SEL[1] turns on the pre-adder, SEL[0] turns on the C post-add
  localparam int SEL_POST_BIT = 0;
  localparam int SEL_PRE_BIT  = 1;

  // Pre-adder keeps one extra bit so A+D never wraps
  function automatic int pre_width(input int width_in);
    return width_in + 1;
  endfunction

  // (WIDTH_IN+1) x WIDTH_IN product
  function automatic int prod_width(input int width_in);
    return 2 * width_in + 1;
  endfunction

  localparam int DEFAULT_WIDTH_IN  = 4;
  localparam int DEFAULT_WIDTH_OUT = 10;
  localparam int PRE_WIDTH         = pre_width(DEFAULT_WIDTH_IN);
  localparam int PROD_WIDTH        = prod_width(DEFAULT_WIDTH_IN);

endpackage

// File: rtl/dsp_macro_if.sv
// rtl/dsp_macro_if.sv - operand/result bundle between operand memories and dsp_macro
//
// Purpose: groups the per-sample operands and the result of dsp_macro.
// Ports:   SEL, CARRYIN, A, B, C, D  driven by the master (operand source)
//          P                         driven by the slave (dsp_macro)

interface dsp_macro_if #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 10
);

  logic [1:0]           SEL;
  logic                 CARRYIN;
  logic [WIDTH_IN-1:0]  A;
  logic [WIDTH_IN-1:0]  B;
  logic [WIDTH_IN-1:0]  C;
  logic [WIDTH_IN-1:0]  D;
  logic [WIDTH_OUT-1:0] P;

  modport master (
    output SEL, CARRYIN, A, B, C, D,
    input  P
  );

  modport slave (
    input  SEL, CARRYIN, A, B, C, D,
    output P
  );

endinterface

// File: rtl/dsp_macro_preadd_mult.sv
// rtl/dsp_macro_preadd_mult.sv - S2 stage: optional pre-add of D onto A, multiply by B, register
//
// Purpose: registers M = (pre_en ? A+D : A) * B at full product precision.
// Ports:   CLK     in   rising-edge clock
//          reset   in   synchronous active-high reset, clears M
//          a, b, d in   S1-registered operands
//          pre_en  in   S1-registered SEL[1]
//          m       out  registered product, prod_width(WIDTH_IN) bits

module dsp_preadd_mult
  import dsp_macro_pkg::*;
#(
  parameter int WIDTH_IN = 4
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic [WIDTH_IN-1:0]            a,
  input  logic [WIDTH_IN-1:0]            b,
  input  logic [WIDTH_IN-1:0]            d,
  input  logic                           pre_en,
  output logic [prod_width(WIDTH_IN)-1:0] m
);

  localparam int PRE_W  = pre_width(WIDTH_IN);
  localparam int PROD_W = prod_width(WIDTH_IN);

  logic [PRE_W-1:0]  pre_sum;
  logic [PROD_W-1:0] product;

  always_comb begin
    pre_sum = PRE_W'(a) + (pre_en ? PRE_W'(d) : '0);
    product = PROD_W'(pre_sum) * PROD_W'(b);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      m <= '0;
    end else begin
      m <= product;
    end
  end

endmodule

// File: rtl/dsp_macro.sv
// rtl/dsp_macro.sv - 3-stage streaming pre-add / multiply / post-add unit
//
// Purpose: P = (SEL[1] ? A+D : A) * B + (SEL[0] ? C : 0) + CARRYIN, mod 2^WIDTH_OUT,
//          one sample per clock, result visible after the third edge.
// Ports:   CLK    in   rising-edge clock
//          reset  in   synchronous active-high reset, clears every stage
//          bus    slave side of dsp_macro_if (SEL, CARRYIN, A, B, C, D in; P out)

module dsp_macro
  import dsp_macro_pkg::*;
#(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 10
) (
  input  logic      CLK,
  input  logic      reset,
  dsp_macro_if.slave bus
);

  localparam int PROD_W = prod_width(WIDTH_IN);
  // Post-add needs one more bit than the product; widen further if P is wider still
  localparam int FULL_W = (PROD_W + 1 > WIDTH_OUT) ? PROD_W + 1 : WIDTH_OUT;

  // S1: raw operand capture
  logic [1:0]          s1_sel;
  logic                s1_cin;
  logic [WIDTH_IN-1:0] s1_a;
  logic [WIDTH_IN-1:0] s1_b;
  logic [WIDTH_IN-1:0] s1_c;
  logic [WIDTH_IN-1:0] s1_d;

  // S2: product plus the post-add controls that travel with it
  logic [PROD_W-1:0]   s2_m;
  logic [WIDTH_IN-1:0] s2_c;
  logic                s2_post_en;
  logic                s2_cin;

  // S3: result
  logic [FULL_W-1:0]    full_sum;
  logic [WIDTH_OUT-1:0] p_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_sel <= '0;
      s1_cin <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_c   <= '0;
      s1_d   <= '0;
    end else begin
      s1_sel <= bus.SEL;
      s1_cin <= bus.CARRYIN;
      s1_a   <= bus.A;
      s1_b   <= bus.B;
      s1_c   <= bus.C;
      s1_d   <= bus.D;
    end
  end

  dsp_preadd_mult #(
    .WIDTH_IN (WIDTH_IN)
  ) u_preadd_mult (
    .CLK    (CLK),
    .reset  (reset),
    .a      (s1_a),
    .b      (s1_b),
    .d      (s1_d),
    .pre_en (s1_sel[SEL_PRE_BIT]),
    .m      (s2_m)
  );

  // Delay line keeping C and its controls aligned with the product
  always_ff @(posedge CLK) begin
    if (reset) begin
      s2_c       <= '0;
      s2_post_en <= 1'b0;
      s2_cin     <= 1'b0;
    end else begin
      s2_c       <= s1_c;
      s2_post_en <= s1_sel[SEL_POST_BIT];
      s2_cin     <= s1_cin;
    end
  end

  always_comb begin
    full_sum = FULL_W'(s2_m)
             + (s2_post_en ? FULL_W'(s2_c) : '0)
             + FULL_W'(s2_cin);
  end

  // Truncation gives the modulo-2^WIDTH_OUT wrap when P is narrow
  always_ff @(posedge CLK) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= full_sum[WIDTH_OUT-1:0];
    end
  end

  assign bus.P = p_q;

endmodule

// File: tb/tb_dsp_macro.sv
// tb/tb_dsp_macro.sv - scoreboard bench for dsp_macro at WIDTH_OUT=10 and WIDTH_OUT=8

module tb_dsp_macro;
  import dsp_macro_pkg::*;

  logic CLK = 1'b0;
  logic reset = 1'b1;

  dsp_macro_if #(.WIDTH_IN(4), .WIDTH_OUT(10)) bus10 ();
  dsp_macro_if #(.WIDTH_IN(4), .WIDTH_OUT(8))  bus8 ();

  dsp_macro #(.WIDTH_IN(4), .WIDTH_OUT(10)) dut10 (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus10.slave)
  );

  dsp_macro #(.WIDTH_IN(4), .WIDTH_OUT(8)) dut8 (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus8.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string name;
    int    exp;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  // Recent stimulus history, index 0 = sample taken at the coming edge
  int    hv[3];
  bit    hr[3];
  string hn[3];

  // Reference: operation table evaluated with plain integer arithmetic
  function automatic int ref_op(input logic [1:0] sel, input int a, input int b,
                                input int c, input int d, input bit cin);
    case (sel)
      OP_AB:    return a * b + int'(cin);
      OP_AB_C:  return a * b + c + int'(cin);
      OP_ADB:   return (a + d) * b + int'(cin);
      default:  return (a + d) * b + c + int'(cin);
    endcase
  endfunction

  // One sample per edge; P after an edge shows the sample from two edges earlier,
  // unless a reset edge fell anywhere in that window.
  task automatic drive(input bit rst, input logic [1:0] sel, input int a, input int b,
                       input int c, input int d, input bit cin, input string name);
    exp_t e;
    @(negedge CLK);
    reset         = rst;
    bus10.SEL     = sel;  bus8.SEL     = sel;
    bus10.CARRYIN = cin;  bus8.CARRYIN = cin;
    bus10.A = 4'(a);  bus8.A = 4'(a);
    bus10.B = 4'(b);  bus8.B = 4'(b);
    bus10.C = 4'(c);  bus8.C = 4'(c);
    bus10.D = 4'(d);  bus8.D = 4'(d);
    for (int i = 2; i > 0; i--) begin
      hv[i] = hv[i-1];
      hr[i] = hr[i-1];
      hn[i] = hn[i-1];
    end
    hv[0] = ref_op(sel, a, b, c, d, cin);
    hr[0] = rst;
    hn[0] = name;
    if (hr[0] || hr[1] || hr[2]) begin
      e.name = "reset_zero";
      e.exp  = 0;
    end else begin
      e.name = hn[2];
      e.exp  = hv[2];
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, OP_AB, 0, 0, 0, 0, 1'b0, "idle");
  endtask

  task automatic rand_sample(input bit rst, input string name);
    drive(rst, 2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)), name);
  endtask

  // Monitor: every edge, compare both DUTs against the next scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus10.P !== 10'(e.exp)) begin
          errors++;
          $display("FAIL %s w10: P=%0d expected %0d", e.name, bus10.P, e.exp);
        end
        checks++;
        if (bus8.P !== 8'(e.exp % 256)) begin
          errors++;
          $display("FAIL %s w8: P=%0d expected %0d", e.name, bus8.P, e.exp % 256);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      hv[i] = 0;
      hr[i] = 1'b1;
      hn[i] = "init";
    end

    // Reset held with random inputs, then zeros after release
    rand_sample(1'b1, "reset");
    rand_sample(1'b1, "reset");
    idle(2);

    // Directed operations, isolated by zero samples
    drive(1'b0, OP_AB,    3,  5,  0,  0, 1'b1, "ab_16");
    idle(2);
    drive(1'b0, OP_AB_C,  15, 15, 15, 0, 1'b1, "abc_241");
    drive(1'b0, OP_ADB,   7,  10, 0,  9, 1'b0, "adb_160");
    drive(1'b0, OP_ADB_C, 15, 15, 15, 15, 1'b1, "adbc_466");
    idle(2);

    // Operation changes every cycle
    drive(1'b0, OP_AB,    2, 3, 4, 1, 1'b0, "stream_6");
    drive(1'b0, OP_AB_C,  2, 3, 4, 1, 1'b0, "stream_10");
    drive(1'b0, OP_ADB,   2, 3, 4, 1, 1'b0, "stream_9");
    drive(1'b0, OP_ADB_C, 2, 3, 4, 1, 1'b0, "stream_13");
    idle(2);

    // Reset while samples are in flight
    rand_sample(1'b0, "pre_rst");
    rand_sample(1'b0, "pre_rst");
    rand_sample(1'b0, "pre_rst");
    drive(1'b1, OP_ADB_C, 15, 15, 15, 15, 1'b1, "midrst");
    drive(1'b0, OP_ADB, 7, 10, 0, 9, 1'b0, "post_rst_160");
    idle(2);

    // Random stream with occasional reset
    for (int i = 0; i < 10000; i++) begin
      rand_sample(($urandom_range(0, 255) == 0), "rand");
    end
    idle(2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge CLK);
      #2;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
